// File: rtl/pwr_clk_pkg.sv
// rtl/pwr_clk_pkg.sv - shared phase encodings and constants for the power-clock scheduler
//
// Purpose: phase enum, requester indices and the default phase length used by
// pwr_clk_phase_gen and pwr_clk_mux_scheduler.
// Ports: none (package).
package pwr_clk_pkg;

  typedef enum logic [1:0] {
    PH_WAIT    = 2'd0,
    PH_EVAL    = 2'd1,
    PH_HOLD    = 2'd2,
    PH_RECOVER = 2'd3
  } phase_e;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  localparam int PHASE_LEN_DEFAULT = 4;

  // Fixed four-phase rotation of the power clock.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_WAIT:    next_phase = PH_EVAL;
      PH_EVAL:    next_phase = PH_HOLD;
      PH_HOLD:    next_phase = PH_RECOVER;
      default:    next_phase = PH_WAIT;
    endcase
  endfunction

endpackage

// File: rtl/pwr_clk_phase_gen.sv
// rtl/pwr_clk_phase_gen.sv - four-phase power-clock sequencer with enable parking
//
// Purpose: steps WAIT->EVAL->HOLD->RECOVER, each phase PHASE_LEN clks, and drives
// the registered pulsed power clock (high in EVAL and HOLD).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en_i            - run enable, only looked at on the last WAIT clk
//   phase_o         - current phase encoding
//   last_cycle_o    - high on the last clk of the current phase
//   phase_start_o   - high on the first clk of a phase that was just entered
//   pwr_clk_o       - pulsed power clock
module pwr_clk_phase_gen
  import pwr_clk_pkg::*;
#(
  parameter int PHASE_LEN = PHASE_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [1:0] phase_o,
  output logic       last_cycle_o,
  output logic       phase_start_o,
  output logic       pwr_clk_o
);

  localparam int CNT_W = ($clog2(PHASE_LEN) > 0) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PHASE_LEN - 1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwr_q, pwr_d;
  logic             start_q, start_d;
  logic             last;
  logic             advance;

  assign last = (cnt_q == CNT_MAX);
  // Only WAIT can stall; every other phase always moves on after PHASE_LEN clks.
  assign advance = last && ((phase_q != PH_WAIT) || en_i);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (advance) begin
      phase_d = next_phase(phase_q);
      cnt_d   = '0;
    end else if (!last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Parked in WAIT: cnt stays at CNT_MAX so en is re-sampled every clk.
    pwr_d   = (phase_d == PH_EVAL) || (phase_d == PH_HOLD);
    start_d = advance;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_WAIT;
      cnt_q   <= '0;
      pwr_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pwr_q   <= pwr_d;
      start_q <= start_d;
    end
  end

  assign phase_o       = phase_q;
  assign last_cycle_o  = last;
  assign phase_start_o = start_q;
  assign pwr_clk_o     = pwr_q;

endmodule

// File: rtl/pwr_clk_mux_scheduler.sv
// rtl/pwr_clk_mux_scheduler.sv - round-robin scheduler and result capture for the pulsed-supply 2:1 mux
//
// Purpose: arbitrates two requesters once per power-clock cycle, drives the mux
// select, captures the mux output at the end of HOLD and returns it.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en         - run enable for the power-clock sequence
//   req[1:0]   - requests (bit0 = path A / sel 0, bit1 = path B / sel 1)
//   mux_y      - mux output
//   gnt[1:0]   - one-hot grant, held EVAL through RECOVER
//   sel        - mux select
//   PwrClk     - pulsed power clock
//   phase[1:0] - current phase
//   y_valid    - one-clk result strobe on the first RECOVER clk
//   y_data     - captured result
//   y_owner    - requester that owns y_data
module pwr_clk_mux_scheduler
  import pwr_clk_pkg::*;
#(
  parameter int PHASE_LEN = PHASE_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       mux_y,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       PwrClk,
  output logic [1:0] phase,
  output logic       y_valid,
  output logic       y_data,
  output logic       y_owner
);

  logic [1:0] phase_w;
  logic       last_w;
  logic       start_w;
  logic       arb_fire;
  logic       winner;

  logic [1:0] gnt_q, gnt_d;
  logic       sel_q, sel_d;
  logic       rr_last_q, rr_last_d;
  logic       y_data_q, y_data_d;
  logic       y_owner_q, y_owner_d;

  pwr_clk_phase_gen #(
    .PHASE_LEN(PHASE_LEN)
  ) u_phase_gen (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .phase_o      (phase_w),
    .last_cycle_o (last_w),
    .phase_start_o(start_w),
    .pwr_clk_o    (PwrClk)
  );

  // Arbitration coincides with the WAIT->EVAL edge, so sel only moves while PwrClk=0.
  assign arb_fire = (phase_w == PH_WAIT) && last_w && en;
  assign winner   = ~rr_last_q;

  always_comb begin
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    y_data_d  = y_data_q;
    y_owner_d = y_owner_q;

    if (arb_fire) begin
      case (req)
        2'b01: begin
          gnt_d = 2'b01;
          sel_d = 1'(REQ_A);
        end
        2'b10: begin
          gnt_d = 2'b10;
          sel_d = 1'(REQ_B);
        end
        2'b11: begin
          // Round-robin pointer only moves when there was actually a contest.
          gnt_d     = winner ? 2'b10 : 2'b01;
          sel_d     = winner;
          rr_last_d = winner;
        end
        default: gnt_d = 2'b00;  // idle cycle still runs; sel left untouched
      endcase
    end else if ((phase_w == PH_RECOVER) && last_w) begin
      gnt_d = 2'b00;
    end

    if ((phase_w == PH_HOLD) && last_w && (gnt_q != 2'b00)) begin
      y_data_d  = mux_y;
      y_owner_d = sel_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= 2'b00;
      sel_q     <= 1'b0;
      rr_last_q <= 1'b1;
      y_data_q  <= 1'b0;
      y_owner_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      y_data_q  <= y_data_d;
      y_owner_q <= y_owner_d;
    end
  end

  // gnt_q is still held on the first RECOVER clk and is cleared by reset, so an
  // aborted or idle cycle never strobes.
  assign y_valid = (phase_w == PH_RECOVER) && start_w && (gnt_q != 2'b00);

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign phase   = phase_w;
  assign y_data  = y_data_q;
  assign y_owner = y_owner_q;

endmodule

// File: doc/pwr_clk_mux_scheduler.md
Name: pwr_clk_mux_scheduler

Overview:
Scheduler and power-clock sequencer for the pulsed-supply (adiabatic) 2:1 mux datapath. It generates the four-phase power clock PwrClk and drives the mux select. It round-robin arbitrates two requesters for the single shared mux, one grant per power-clock cycle. It captures the mux output during the HOLD phase and returns it to the granted requester.

Parameters:
PHASE_LEN, 4, clk cycles per power-clock phase; legal range 1..16.
CNT_W, $clog2(PHASE_LEN)>0 ? $clog2(PHASE_LEN) : 1, phase counter width (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  run enable for the power-clock cycle sequence
req  input  2  request; bit0 = path A (sel=0), bit1 = path B (sel=1)
mux_y  input  1  Y output of the low-power mux
gnt  output  2  one-hot grant, held EVAL through RECOVER
sel  output  1  mux select
PwrClk  output  1  pulsed power clock to mux
phase  output  2  current phase: 0 WAIT, 1 EVAL, 2 HOLD, 3 RECOVER
y_valid  output  1  single-cycle result strobe
y_data  output  1  captured mux result
y_owner  output  1  requester index the result belongs to

Behaviour:
- Reset (async, immediate, also mid-cycle): phase=WAIT, cnt=0, PwrClk=0, sel=0, gnt=00, y_valid=0, y_data=0, y_owner=0, rr_last=1, so the first tie goes to req[0]. No y_valid is issued for an aborted cycle.
- Phase FSM: WAIT->EVAL->HOLD->RECOVER->WAIT. Each phase lasts exactly PHASE_LEN clks. cnt runs 0..PHASE_LEN-1 and wraps to 0 on each phase change. PHASE_LEN=1 gives 1 clk per phase.
- PwrClk is registered: 1 throughout EVAL and HOLD, 0 in WAIT and RECOVER.
- en: sampled only on the last WAIT cycle. en=0 parks the FSM in WAIT with cnt held at PHASE_LEN-1 and PwrClk=0. Deasserting en mid-cycle does not abort the cycle; it completes through RECOVER.
- Arbitration: on the last WAIT cycle with en=1:
  - Only one req bit set: grant that requester.
  - Both set: grant ~rr_last, then update rr_last.
  - req=00: gnt=00, sel keeps its previous value, the cycle still runs, no y_valid.
- sel and gnt are registered at the WAIT->EVAL edge. They stay constant through EVAL, HOLD and RECOVER; sel never changes while PwrClk=1. gnt returns to 00 on the RECOVER->WAIT edge.
- Requests withdrawn after grant do not cancel the cycle. A requester keeps req high to be considered again; there is no back-to-back priority beyond round-robin.
- Capture: on the last HOLD cycle, y_data<=mux_y and y_owner<=sel (granted cycles only). y_valid=1 for exactly the first RECOVER cycle. y_data and y_owner hold until the next capture.
- Latency: arbitration edge t -> EVAL at t+1 -> capture at t+2*PHASE_LEN -> y_valid at t+2*PHASE_LEN+1. Full cycle is 4*PHASE_LEN clks. Throughput is at most 1 result per cycle.

Decomposition:
- Shared package pwr_clk_pkg holds:
  - Phase encodings PH_WAIT=2'd0, PH_EVAL=2'd1, PH_HOLD=2'd2, PH_RECOVER=2'd3.
  - REQ_A=0 and REQ_B=1.
  - Phase-length default constant.
- Sub-module pwr_clk_phase_gen: phase counter, FSM, en parking, PwrClk. It outputs phase, last_cycle_of_phase and phase_start strobes.
- Top level holds the round-robin arbiter, the sel/gnt registers and the capture logic.

Test Plan:
- Reset then en=1, req=01, mux_y tied to 1, PHASE_LEN=4 -> arbitration at clk 3; gnt=01, sel=0 and PwrClk=1 at clks 4-11; y_valid=1 at clk 12 with y_data=1, y_owner=0; gnt=00 at clk 16.
- req=11 held for 3 cycles -> grants 01, 10, 01; y_owner sequence 0, 1, 0; sel toggles only at WAIT->EVAL edges, never while PwrClk=1.
- req=00 for one cycle between granted cycles -> PwrClk still pulses for 8 clks, gnt=00, no y_valid, sel keeps its last value.
- en=0 asserted during HOLD -> the cycle completes, y_valid is still issued, then phase stays WAIT with PwrClk=0. en=1 restarts EVAL 1 clk after the next sampling cycle.
- rst pulsed during HOLD with a grant active -> all outputs return to reset values within the same cycle, no y_valid. After release, the first tie (req=11) grants req[0].
- PHASE_LEN=1, req=10, mux_y=0 -> phases advance every clk; y_valid at the 3rd clk after arbitration with y_data=0, y_owner=1.
